block_scan_counter: RTL and testbench

- Parametrised coordinate generator for the image-compression datapath. Replaces fixed-width free-running counters with a start/done-controlled scan sequencer.
- Emits one (x, y) pixel coordinate per accepted beat over a valid/ready interface.
- Two scan orders:
  - full-frame raster;
  - block-tiled, BLK x BLK tiles, raster inside each tile, tiles in raster order.
- Feeds the frame-buffer read address logic and the block transform front end.

---
 rtl/block_scan_counter.sv | 211 +++++++++++++++++++++
 tb/tb_block_scan_counter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_scan_counter.sv
// block_scan_counter
//   Start/done controlled coordinate sequencer for the image-compression
//   datapath. Emits one (x, y) pixel coordinate per accepted valid/ready beat,
//   either as a full-frame raster or as BLK x BLK tiles (raster inside each
//   tile, tiles in raster order).
//
//   State table
//     state  | meaning
//     -------+-----------------------------------------------------------
//     IDLE   | waiting for start; outputs quiet, counters cleared
//     RUN    | presenting coordinates, advancing on each accepted beat
//     DONE   | one cycle after the final beat; done pulses, busy still high
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   begin a frame scan (IDLE only)
//   mode       in   0 = raster, 1 = block-tiled; latched on accepted start
//   abort      in   synchronous cancel of the running scan
//   out_ready  in   consumer ready
//   out_valid  out  coordinate valid
//   x, y       out  pixel column / row, COORD_W bits each
//   blk_last   out  last pixel of a tile (block mode only)
//   frame_last out  last pixel of the frame
//   busy       out  high in RUN and DONE
//   done       out  one-cycle pulse after the final beat is accepted

module block_scan_counter #(
  parameter int COORD_W = 10,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int BLK     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               blk_last,
  output logic               frame_last,
  output logic               busy,
  output logic               done
);

  localparam int PW  = $clog2(BLK);
  localparam int NBX = IMG_W / BLK;
  localparam int NBY = IMG_H / BLK;
  localparam int BXW = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int BYW = (NBY > 1) ? $clog2(NBY) : 1;

  localparam logic [PW-1:0]  P_MAX  = PW'(BLK - 1);
  localparam logic [BXW-1:0] BX_MAX = BXW'(NBX - 1);
  localparam logic [BYW-1:0] BY_MAX = BYW'(NBY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  logic           mode_q;
  logic [PW-1:0]  px;
  logic [PW-1:0]  py;
  logic [BXW-1:0] bx;
  logic [BYW-1:0] by;

  logic [PW-1:0]  px_n;
  logic [PW-1:0]  py_n;
  logic [BXW-1:0] bx_n;
  logic [BYW-1:0] by_n;
  logic           blk_last_n;
  logic           frame_last_n;

  // The same four counters serve both orders: raster carries px -> bx -> py
  // -> by, block mode carries px -> py -> bx -> by. The tile counters are the
  // upper bits of the coordinate, so x = {bx, px} and y = {by, py}.
  always_comb begin
    px_n = px;
    py_n = py;
    bx_n = bx;
    by_n = by;
    if (px != P_MAX) begin
      px_n = px + 1'b1;
    end else begin
      px_n = '0;
      if (mode_q) begin
        if (py != P_MAX) begin
          py_n = py + 1'b1;
        end else begin
          py_n = '0;
          if (bx != BX_MAX) begin
            bx_n = bx + 1'b1;
          end else begin
            bx_n = '0;
            if (by != BY_MAX) by_n = by + 1'b1;
          end
        end
      end else begin
        if (bx != BX_MAX) begin
          bx_n = bx + 1'b1;
        end else begin
          bx_n = '0;
          if (py != P_MAX) begin
            py_n = py + 1'b1;
          end else begin
            py_n = '0;
            if (by != BY_MAX) by_n = by + 1'b1;
          end
        end
      end
    end
    blk_last_n   = mode_q && (px_n == P_MAX) && (py_n == P_MAX);
    frame_last_n = (px_n == P_MAX) && (py_n == P_MAX) &&
                   (bx_n == BX_MAX) && (by_n == BY_MAX);
  end

  logic [BXW+PW-1:0] x_cat;
  logic [BYW+PW-1:0] y_cat;

  assign x_cat = {bx, px};
  assign y_cat = {by, py};
  assign x     = COORD_W'(x_cat);
  assign y     = COORD_W'(y_cat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      px         <= '0;
      py         <= '0;
      bx         <= '0;
      by         <= '0;
      out_valid  <= 1'b0;
      blk_last   <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            px         <= '0;
            py         <= '0;
            bx         <= '0;
            by         <= '0;
            out_valid  <= 1'b1;
            blk_last   <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b1;
            state      <= S_RUN;
          end
        end

        S_RUN: begin
          // abort outranks a beat accepted on the same edge, including the
          // final one, so an aborted scan never produces done.
          if (abort) begin
            px         <= '0;
            py         <= '0;
            bx         <= '0;
            by         <= '0;
            out_valid  <= 1'b0;
            blk_last   <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (out_ready) begin
            if (frame_last) begin
              // Clearing here keeps x/y/flags at zero through DONE and IDLE.
              px         <= '0;
              py         <= '0;
              bx         <= '0;
              by         <= '0;
              out_valid  <= 1'b0;
              blk_last   <= 1'b0;
              frame_last <= 1'b0;
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              px         <= px_n;
              py         <= py_n;
              bx         <= bx_n;
              by         <= by_n;
              blk_last   <= blk_last_n;
              frame_last <= frame_last_n;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_scan_counter.sv
// tb_block_scan_counter
//   Self-checking bench for block_scan_counter at IMG_W=16, IMG_H=8, BLK=4.
//   Expected coordinates come from an index-to-coordinate reference model;
//   fixed checkpoints live in a vector table.

module tb_block_scan_counter;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int B  = 4;
  localparam int CW = 10;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic          abort;
  logic          out_ready;
  logic          out_valid;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          blk_last;
  logic          frame_last;
  logic          busy;
  logic          done;

  block_scan_counter #(
    .COORD_W(CW),
    .IMG_W  (W),
    .IMG_H  (H),
    .BLK    (B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .x         (x),
    .y         (y),
    .blk_last  (blk_last),
    .frame_last(frame_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int   cap_x  [N];
  int   cap_y  [N];
  logic cap_bl [N];
  logic cap_fl [N];
  int   nbeats;

  typedef struct {
    logic m;
    int   idx;
    int   ex;
    int   ey;
    logic ebl;
    logic efl;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Beat index -> coordinate, straight from the scan-order definition.
  task automatic model(input logic m, input int i, output int ex, output int ey,
                       output logic ebl, output logic efl);
    int t;
    int w;
    if (!m) begin
      ex  = i % W;
      ey  = i / W;
      ebl = 1'b0;
    end else begin
      t   = i / (B * B);
      w   = i % (B * B);
      ex  = (t % (W / B)) * B + (w % B);
      ey  = (t / (W / B)) * B + (w / B);
      ebl = (w == B * B - 1);
    end
    efl = (i == N - 1);
  endtask

  task automatic check_table(input logic m);
    for (int k = 0; k < 12; k++) begin
      if (tbl[k].m == m) begin
        chk($sformatf("tbl_x[m%0d,%0d]", m, tbl[k].idx), cap_x[tbl[k].idx], tbl[k].ex);
        chk($sformatf("tbl_y[m%0d,%0d]", m, tbl[k].idx), cap_y[tbl[k].idx], tbl[k].ey);
        chk($sformatf("tbl_bl[m%0d,%0d]", m, tbl[k].idx), cap_bl[tbl[k].idx], tbl[k].ebl);
        chk($sformatf("tbl_fl[m%0d,%0d]", m, tbl[k].idx), cap_fl[tbl[k].idx], tbl[k].efl);
      end
    end
  endtask

  // Runs one scan from IDLE. pct = out_ready probability in percent,
  // abort_after >= 0 aborts once that many beats were accepted, poke pulses
  // start (with mode flipped) mid-run and again during DONE.
  task automatic run_scan(input logic m, input int pct, input int abort_after, input bit poke);
    bit            fin;
    bit            aborted;
    bit            stalled;
    int            ndone;
    int            nbl;
    int            ex;
    int            ey;
    logic          ebl;
    logic          efl;
    logic [CW-1:0] px_prev;
    logic [CW-1:0] py_prev;
    logic          pbl_prev;
    logic          pfl_prev;
    nbeats  = 0;
    ndone   = 0;
    fin     = 1'b0;
    aborted = 1'b0;
    stalled = 1'b0;
    px_prev = '0;
    py_prev = '0;
    pbl_prev = 1'b0;
    pfl_prev = 1'b0;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_valid", out_valid, 1);
    chk("start_busy", busy, 1);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (stalled) begin
        chk("stall_x", x, px_prev);
        chk("stall_y", y, py_prev);
        chk("stall_bl", blk_last, pbl_prev);
        chk("stall_fl", frame_last, pfl_prev);
      end
      if (done) ndone++;
      out_ready = ($urandom_range(99) < pct);
      start     = 1'b0;
      if (poke && nbeats == 50 && out_valid) begin
        start = 1'b1;
        mode  = ~m;
      end
      if (abort_after >= 0 && nbeats == abort_after) begin
        abort     = 1'b1;
        out_ready = 1'b1;
        aborted   = 1'b1;
        fin       = 1'b1;
      end else if (out_valid && out_ready) begin
        if (nbeats < N) begin
          cap_x[nbeats]  = int'(x);
          cap_y[nbeats]  = int'(y);
          cap_bl[nbeats] = blk_last;
          cap_fl[nbeats] = frame_last;
        end
        nbeats++;
        if (frame_last === 1'b1) fin = 1'b1;
      end
      stalled  = out_valid && !out_ready;
      px_prev  = x;
      py_prev  = y;
      pbl_prev = blk_last;
      pfl_prev = frame_last;
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    chk("scan_finished", fin, 1);
    chk("done_during_run", ndone, 0);
    if (aborted) begin
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_x", x, 0);
      chk("abort_y", y, 0);
      @(negedge clk);
      chk("abort_done_later", done, 0);
      chk("abort_beats", nbeats, abort_after);
    end else begin
      chk("final_done", done, 1);
      chk("final_valid", out_valid, 0);
      chk("final_busy", busy, 1);
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      @(negedge clk);
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("beat_count", nbeats, N);
    end
    nbl = 0;
    for (int i = 0; i < nbeats && i < N; i++) begin
      model(m, i, ex, ey, ebl, efl);
      chk($sformatf("seq_x[m%0d,%0d]", m, i), cap_x[i], ex);
      chk($sformatf("seq_y[m%0d,%0d]", m, i), cap_y[i], ey);
      chk($sformatf("seq_bl[m%0d,%0d]", m, i), cap_bl[i], ebl);
      chk($sformatf("seq_fl[m%0d,%0d]", m, i), cap_fl[i], efl);
      if (cap_bl[i] === 1'b1) nbl++;
    end
    if (!aborted) chk("blk_last_count", nbl, m ? (N / (B * B)) : 0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 0,   0,  0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 15,  15, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16,  0,  1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 127, 15, 7, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 3,   3,  0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4,   0,  1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 15,  3,  3, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 16,  4,  0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 31,  7,  3, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 64,  0,  4, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 126, 14, 7, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 127, 15, 7, 1'b1, 1'b1};

    rst       = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_bl", blk_last, 0);
    chk("rst_fl", frame_last, 0);
    @(negedge clk);
    rst = 1'b1;

    // Abort is ignored in IDLE.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_valid", out_valid, 0);

    run_scan(1'b0, 100, -1, 1'b0);
    check_table(1'b0);
    run_scan(1'b1, 100, -1, 1'b0);
    check_table(1'b1);

    run_scan(1'b1, 30, -1, 1'b0);
    run_scan(1'b0, 30, -1, 1'b0);

    run_scan(1'b0, 100, 37, 1'b0);
    run_scan(1'b1, 100, -1, 1'b0);

    run_scan(1'b1, 100, -1, 1'b1);
    run_scan(1'b0, 70, -1, 1'b1);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    mode      = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_y", y, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    run_scan(1'b0, 60, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
